// File: rtl/fifo_uart_packetizer.sv
// Pops 24-bit FIFO words and sends each as a UART 8N1 packet: sync, seq, 3 data bytes MSB first.
// Defining PKT_CHECKSUM_EN appends an XOR checksum byte; word-in-IDLE to start bit is 3 cycles.
module fifo_uart_packetizer #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned DATA_WIDTH = 24,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  uart_tx,
  output logic                  busy,
  output logic                  pkt_sent,
  output logic [7:0]            seq
);

`ifdef PKT_CHECKSUM_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 5;
`endif
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [2:0]  BYTE_LAST = 3'(NBYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_POP, S_LATCH, S_SEND, S_DONE} state_t;

  state_t                r_state;
  logic [15:0]           r_div;
  logic [3:0]            r_bit;
  logic [2:0]            r_byte;
  logic [DATA_WIDTH-1:0] r_word;
  logic [7:0]            r_pkt_seq;
  logic [7:0]            r_seq;
  logic                  r_tx;
  logic                  r_rd_en;
  logic                  r_busy;
  logic                  r_sent;

  state_t      w_state_nxt;
  logic [15:0] w_div_nxt;
  logic [3:0]  w_bit_nxt;
  logic [2:0]  w_byte_nxt;
  logic [7:0]  w_byte_val;
  logic [9:0]  w_frame;
  logic        w_tx_nxt;
  logic        w_start;

  assign w_start = enable && !fifo_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_POP;
      S_POP:   w_state_nxt = S_LATCH;
      S_LATCH: begin
        w_state_nxt = S_SEND;
        w_div_nxt   = '0;
        w_bit_nxt   = '0;
        w_byte_nxt  = '0;
      end
      S_SEND: begin
        if (r_div == DIV_LAST) begin
          w_div_nxt = '0;
          if (r_bit == 4'd9) begin
            w_bit_nxt = '0;
            if (r_byte == BYTE_LAST) begin
              w_byte_nxt  = '0;
              w_state_nxt = S_DONE;
            end else begin
              w_byte_nxt = r_byte + 3'd1;
            end
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end else begin
          w_div_nxt = r_div + 16'd1;
        end
      end
      // DONE doubles as the idle decision cycle so back-to-back packets leave only 3 idle-high cycles
      S_DONE:  w_state_nxt = w_start ? S_POP : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef PKT_CHECKSUM_EN
  logic [7:0] w_csum;
  assign w_csum = SYNC_BYTE ^ r_pkt_seq ^ r_word[23:16] ^ r_word[15:8] ^ r_word[7:0];
`endif

  always_comb begin
    w_byte_val = SYNC_BYTE;
    case (w_byte_nxt)
      3'd0:    w_byte_val = SYNC_BYTE;
      3'd1:    w_byte_val = r_pkt_seq;
      3'd2:    w_byte_val = r_word[23:16];
      3'd3:    w_byte_val = r_word[15:8];
      3'd4:    w_byte_val = r_word[7:0];
`ifdef PKT_CHECKSUM_EN
      3'd5:    w_byte_val = w_csum;
`endif
      default: w_byte_val = SYNC_BYTE;
    endcase
  end

  // uart_tx is registered: drive next cycle's frame bit so the line never glitches
  assign w_frame  = {1'b1, w_byte_val, 1'b0};
  assign w_tx_nxt = (w_state_nxt == S_SEND) ? w_frame[w_bit_nxt] : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_word    <= '0;
      r_pkt_seq <= '0;
      r_seq     <= '0;
      r_tx      <= 1'b1;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_sent    <= 1'b0;
    end else begin
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_tx    <= w_tx_nxt;
      r_rd_en <= (w_state_nxt == S_POP);
      r_busy  <= (w_state_nxt == S_POP) || (w_state_nxt == S_LATCH) || (w_state_nxt == S_SEND);
      r_sent  <= (w_state_nxt == S_DONE);
      if (r_state == S_LATCH) begin
        r_word    <= fifo_data_out;
        r_pkt_seq <= r_seq;
      end
      if (w_state_nxt == S_DONE) r_seq <= r_seq + 8'd1;
    end
  end

  assign fifo_rd_en = r_rd_en;
  assign uart_tx    = r_tx;
  assign busy       = r_busy;
  assign pkt_sent   = r_sent;
  assign seq        = r_seq;

endmodule

// File: tb/tb_fifo_uart_packetizer.sv
// Randomized bench: FIFO model plus UART receiver scoreboard; expected packets are queued when a word is popped.
module tb_fifo_uart_packetizer;
  localparam int CLK_DIV = 4;
`ifdef PKT_CHECKSUM_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 5;
`endif
  localparam int PKT_BUSY = 2 + NBYTES * 10 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [23:0] fifo_data_out = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en, uart_tx, busy, pkt_sent;
  logic [7:0]  seq;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int rd_pulses = 0;
  logic [23:0] fq[$];
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  fifo_uart_packetizer #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(24), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .uart_tx(uart_tx),
    .busy(busy), .pkt_sent(pkt_sent), .seq(seq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference packet: sync, sequence (= pops since reset), word MSB first, optional XOR checksum
  task automatic push_expected(input logic [23:0] w, input logic [7:0] s);
    exp_q.push_back(8'hA5);
    exp_q.push_back(s);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
`ifdef PKT_CHECKSUM_EN
    exp_q.push_back(8'hA5 ^ s ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
  endtask

  // FIFO model: serves pops and produces expected packets
  initial begin : fifo_model
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        pops = 0;
      end else if (fifo_rd_en) begin
        rd_pulses++;
        check("pop_while_empty", 32'(fq.size() == 0), 32'd0);
        if (fq.size() > 0) begin
          fifo_data_out = fq.pop_front();
          push_expected(fifo_data_out, pops[7:0]);
          pops++;
        end
      end
      fifo_empty = (fq.size() == 0);
    end
  end

  // UART receiver: every bit must hold CLK_DIV cycles, framing 0..1, byte matches the scoreboard
  initial begin : uart_mon
    logic [9:0] fr;
    logic [7:0] e;
    bit glitch, abort;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx == 1'b0) begin
        fr = '0; glitch = 0; abort = 0;
        for (int k = 0; k < 10 * CLK_DIV; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin abort = 1; break; end
          if (k % CLK_DIV == 0) fr[k / CLK_DIV] = uart_tx;
          else if (uart_tx !== fr[k / CLK_DIV]) glitch = 1;
        end
        if (!abort) begin
          check("uart_framing", {29'd0, glitch, fr[9], fr[0]}, 32'b010);
          check("unexpected_byte", 32'(exp_q.size() == 0), 32'd0);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("uart_byte", {24'd0, fr[8:1]}, {24'd0, e});
          end
        end
      end
    end
  end

  initial begin : busy_mon
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst) run = 0;
      else if (busy) run++;
      else if (run > 0) begin
        check("busy_len", run, PKT_BUSY);
        check("pkt_sent_at_busy_fall", {31'd0, pkt_sent}, 32'd1);
        run = 0;
      end else if (pkt_sent) check("stray_pkt_sent", {31'd0, pkt_sent}, 32'd0);
    end
  end

  task automatic push_word(input logic [23:0] w);
    fq.push_back(w);
  endtask

  task automatic drive_tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_quiet(input int budget);
    int q;
    q = 0;
    for (int i = 0; i < budget && q < 2; i++) begin
      @(negedge clk);
      if (fq.size() == 0 && !busy && exp_q.size() == 0 && !fifo_rd_en && uart_tx) q++;
      else q = 0;
    end
    if (q < 2) check("timeout_quiet", 32'd1, 32'd0);
  endtask

  task automatic wait_sig(input int budget, input bit want_sent);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = want_sent ? pkt_sent : fifo_rd_en;
    end
    if (!hit) check(want_sent ? "timeout_pkt_sent" : "timeout_rd_en", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    drive_tick();
    rst = 1'b1;
    drive_tick();
    @(negedge clk);
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_seq", {24'd0, seq}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_pkt_sent", {31'd0, pkt_sent}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin : main
    int base, gap, lowcnt;
    do_reset();

    // Single packet 0x123456
    drive_tick();
    push_word(24'h123456);
    enable = 1'b1;
    wait_quiet(2000);
    check("seq_after_one", {24'd0, seq}, 32'd1);
    check("rd_pulses_one", rd_pulses, 1);

    // Back-to-back packets and the idle gap between them
    drive_tick();
    enable = 1'b0;
    push_word(24'hABCDEF);
    push_word(24'h000001);
    drive_tick();
    enable = 1'b1;
    wait_sig(2000, 1'b1);
    gap = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_tx == 1'b0) break;
      gap++;
    end
    check("inter_pkt_gap", gap, 3);
    wait_quiet(2000);
    check("seq_after_three", {24'd0, seq}, 32'd3);
    check("rd_pulses_three", rd_pulses, 3);

    // Drop enable during the third data byte's predecessor (0x34) with words still queued
    base = rd_pulses;
    drive_tick();
    push_word(24'h123456);
    push_word($urandom);
    push_word($urandom);
    wait_sig(200, 1'b0);
    repeat (2 + 3 * 10 * CLK_DIV + 10) @(negedge clk);
    drive_tick();
    enable = 1'b0;
    wait_sig(2000, 1'b1);
    lowcnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!uart_tx) lowcnt++;
    end
    check("no_pop_after_disable", rd_pulses - base, 1);
    check("tx_idle_after_disable", lowcnt, 0);
    check("scoreboard_drained_disable", exp_q.size(), 0);

    // Reset during the seq byte abandons the packet; next word restarts at seq 0
    drive_tick();
    enable = 1'b1;
    wait_sig(200, 1'b0);
    repeat (2 + 10 * CLK_DIV + 10) @(negedge clk);
    do_reset();
    wait_quiet(2000);
    check("seq_after_reset_pkt", {24'd0, seq}, 32'd1);

    // Randomized words, enable toggling and idle times
    for (int n = 0; n < 15; n++) begin
      drive_tick();
      push_word($urandom);
      enable = $urandom_range(0, 3) != 0;
      repeat ($urandom_range(0, 150)) @(posedge clk);
    end
    drive_tick();
    enable = 1'b1;
    wait_quiet(15 * (PKT_BUSY + 10) + 1000);
    check("seq_after_random", {24'd0, seq}, {24'd0, pops[7:0]});

    // 256 packets: the last carries seq 0xFF and the counter wraps to 0
    do_reset();
    base = rd_pulses;
    drive_tick();
    for (int n = 0; n < 256; n++) push_word($urandom);
    wait_quiet(256 * (PKT_BUSY + 10) + 1000);
    check("pops_256", rd_pulses - base, 256);
    check("seq_wrap", {24'd0, seq}, 32'd0);
    check("scoreboard_empty_end", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
